seq_divmod_unit: RTL and testbench

- Multi-cycle signed divide/modulo execution unit for the hardwired-control datapath.
- Consumes the isDiv/isMod decode outputs of the control unit plus the two register-file operands; returns the quotient or remainder to the writeback mux.
- Uses restoring shift-subtract division, one quotient bit per clock, with a start/busy/done handshake so the pipeline stalls while busy.

---
 rtl/seq_divmod_unit.sv | 109 ++++++++++
 tb/tb_seq_divmod_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/seq_divmod_unit.sv
// Multi-cycle signed divide/modulo unit: restoring shift-subtract, one quotient
// bit per clock, with magnitude arithmetic and a final sign fix-up.
module seq_divmod_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_mod,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    state_t state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, babs, quo, rem;
    logic [CW-1:0]    cnt;
    logic             mode_mod, sign_a, sign_b, dbz;
    logic             accept;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] q_fix, r_fix, res_next;

    assign accept = start && (is_div || is_mod);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (accept) state_next = PREP;
            PREP:    state_next = (b_reg == '0) ? FIX : ITER;
            ITER:    if (cnt == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Trial subtract one bit wider than the operands so the borrow is the sign.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        trial    = rem_sh - {1'b0, babs};
        q_fix    = (sign_a ^ sign_b) ? -quo : quo;
        r_fix    = sign_a ? -rem : rem;
        res_next = dbz ? (mode_mod ? a_reg : '1) : (mode_mod ? r_fix : q_fix);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            babs        <= '0;
            quo         <= '0;
            rem         <= '0;
            cnt         <= '0;
            mode_mod    <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dbz         <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: if (accept) begin
                    a_reg    <= op_a;
                    b_reg    <= op_b;
                    mode_mod <= ~is_div;
                    sign_a   <= op_a[WIDTH-1];
                    sign_b   <= op_b[WIDTH-1];
                end
                PREP: begin
                    quo  <= sign_a ? -a_reg : a_reg;
                    babs <= sign_b ? -b_reg : b_reg;
                    rem  <= '0;
                    cnt  <= CNT_INIT;
                    dbz  <= (b_reg == '0);
                end
                ITER: begin
                    if (trial[WIDTH]) begin
                        rem <= rem_sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    result      <= res_next;
                    div_by_zero <= dbz;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divmod_unit.sv
// Directed bench for seq_divmod_unit: signs, divide-by-zero, overflow,
// ignored starts, back-to-back issue and mid-operation reset.
module tb_seq_divmod_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, start, is_div, is_mod;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result;
    int           pass_cnt = 0;
    int           fail_cnt = 0;
    int           total    = 0;

    seq_divmod_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_div(is_div), .is_mod(is_mod),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request across one rising edge; returns 1 ns after that edge.
    task automatic issue(input logic d, input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; is_div = d; is_mod = m; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the accept edge until done; optionally fires stray starts.
    task automatic wait_done(input string tag, input int lat, input logic [W-1:0] er,
                             input logic edbz, input bit ghost);
        int n = 0;
        while (n < 100 && !done) begin
            if (ghost && (n == 4 || n == 19)) begin
                start = 1'b1; is_div = 1'b0; is_mod = 1'b1; op_a = 999; op_b = 5;
            end else start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_res"}, result, er);
        chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
        chk({tag, "_busy"}, {31'b0, busy}, '0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; is_div = 1'b0; is_mod = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, '0);
        chk("rst_done", {31'b0, done}, '0);
        chk("rst_res", result, '0);
        chk("rst_dbz", {31'b0, div_by_zero}, '0);
        @(negedge clk) rst_n = 1'b1;

        issue(1, 0, 100, 7);
        chk("div_busy", {31'b0, busy}, 32'd1);
        wait_done("div_pos", 34, 32'd14, 0, 0);
        @(posedge clk); #1;
        chk("done_single", {31'b0, done}, '0);

        issue(0, 1, -100, 7);  wait_done("mod_na", 34, 32'hFFFF_FFFE, 0, 0);
        issue(1, 0, -100, 7);  wait_done("div_na", 34, 32'hFFFF_FFF2, 0, 0);
        issue(1, 0, 100, -7);  wait_done("div_nb", 34, 32'hFFFF_FFF2, 0, 0);
        issue(0, 1, 100, -7);  wait_done("mod_nb", 34, 32'd2, 0, 0);
        issue(1, 1, 100, 7);   wait_done("both_flags", 34, 32'd14, 0, 0);

        issue(1, 0, 7, 0);     wait_done("div_z", 2, 32'hFFFF_FFFF, 1, 0);
        issue(0, 1, 7, 0);     wait_done("mod_z", 2, 32'd7, 1, 0);

        issue(1, 0, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("ovf_div", 34, 32'h8000_0000, 0, 0);
        issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("ovf_mod", 34, 32'd0, 0, 0);

        issue(1, 0, 100, 7);   wait_done("ghost", 34, 32'd14, 0, 1);
        @(posedge clk); #1;
        chk("ghost_not_queued", {31'b0, busy}, '0);

        issue(0, 0, 5, 1);
        chk("noflag_busy", {31'b0, busy}, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("noflag_done", {31'b0, done}, '0);
        chk("noflag_res", result, 32'd14);

        // Second request presented in the done cycle of the first.
        issue(0, 1, 100, -7);  wait_done("b2b_first", 34, 32'd2, 0, 0);
        start = 1'b1; is_div = 1'b1; is_mod = 1'b0; op_a = 1000; op_b = 3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_hold", result, 32'd2);
        wait_done("b2b_second", 34, 32'd333, 0, 0);

        issue(1, 0, 12345, 7);
        repeat (11) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_busy", {31'b0, busy}, '0);
        chk("mrst_done", {31'b0, done}, '0);
        chk("mrst_res", result, '0);
        chk("mrst_dbz", {31'b0, div_by_zero}, '0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("mrst_no_done", seen, 0);
        issue(1, 0, 12345, -100); wait_done("after_rst", 34, 32'hFFFF_FF85, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
